pipelined_long_divider: RTL and testbench
=========================================

Name: pipelined_long_divider

Overview:
- Pipelined unsigned restoring long divider. It is the inverse companion of the pipelined long multiplier in the integer arithmetic library.
- Divides an N-bit dividend by an N-bit divisor and produces an N-bit quotient and an N-bit remainder.
- Pipeline depth is a parameter, so frequency and latency can be traded off.
- Accepts one operation per enabled cycle and is fully streaming, with no backpressure.

Parameters:
- DATA_WIDTH, 16: operand, quotient and remainder width. Must be a power of 2.
- PIPELINE_DEPTH, 4: number of pipeline stages. Must divide DATA_WIDTH; legal range 1 to DATA_WIDTH.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- clk_en_i  input  1  pipeline advance enable.
- dividend_i  input  DATA_WIDTH  unsigned dividend.
- divisor_i  input  DATA_WIDTH  unsigned divisor.
- data_valid_i  input  1  operands valid this cycle.
- quotient_o  output  DATA_WIDTH  registered quotient.
- remainder_o  output  DATA_WIDTH  registered remainder.
- data_valid_o  output  1  quotient_o and remainder_o valid.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Local constant BITS_PER_STAGE = DATA_WIDTH / PIPELINE_DEPTH.
- Stage k computes quotient bits [DATA_WIDTH-1-k*BITS_PER_STAGE -: BITS_PER_STAGE], MSB first.
- Per quotient bit:
  - trial = {rem[DATA_WIDTH-1:0], next dividend bit}, DATA_WIDTH+1 bits wide;
  - if trial >= {1'b0, divisor}: rem = trial - divisor and q bit = 1;
  - else: rem = trial and q bit = 0.
- Stage 0 starts from rem = 0.
- Every stage output is registered. Each stage register holds:
  - partial remainder (DATA_WIDTH bits);
  - partial quotient (DATA_WIDTH bits; unresolved low bits are held as the remaining dividend bits, shift-register style);
  - divisor;
  - valid.
- Latency: exactly PIPELINE_DEPTH enabled cycles from data_valid_i sampled to data_valid_o. quotient_o and remainder_o come straight from the final stage register.
- Throughput: one operation per enabled cycle. There is no ready signal and the block never stalls itself.
- clk_en_i = 0: all stage registers, including valid, hold their values. Outputs stay stable.
- data_valid_i = 0: the bubble propagates with valid = 0. Data registers still load (don't-care contents). data_valid_o = 0 for that slot.
- Divide by zero: the algorithm inherently yields quotient_o = all ones and remainder_o = dividend. This behaviour is required, and no special-case logic is added.
- divisor > dividend: quotient_o = 0 and remainder_o = dividend.
- Reset: rst_i = 1 at a clock edge clears every stage register, so quotient_o = 0, remainder_o = 0 and data_valid_o = 0.
  - Reset overrides clk_en_i.
  - In-flight operations are discarded. No data_valid_o pulse appears for them after reset deasserts.
- Outputs are defined only when data_valid_o = 1.

Optional Feature:
- Macro: PIPELINED_LONG_DIVIDER_DBZ_FLAG_EN.
- When defined:
  - adds output port divide_by_zero_o (1 bit);
  - a stage-0 comparator detects divisor_i == 0, and the result travels down the pipeline alongside valid;
  - divide_by_zero_o is asserted with data_valid_o for the same operation;
  - it resets to 0 and holds under clk_en_i = 0.
- When undefined: the port and its registers are absent. Quotient and remainder behaviour is identical either way.

Decomposition:
- No shared package is needed. BITS_PER_STAGE and REM_WIDTH (DATA_WIDTH+1) are localparams.
- Elaboration-time assertion: DATA_WIDTH % PIPELINE_DEPTH == 0.
- Sub-module pipelined_long_divider_stage (parameters DATA_WIDTH, BITS_PER_STAGE):
  - purely combinational;
  - inputs: partial remainder, remaining dividend bits, divisor;
  - outputs: next partial remainder, shifted dividend/quotient word.
- The top level instantiates PIPELINE_DEPTH stages via generate and owns all registers.

Test Plan (DATA_WIDTH=16, PIPELINE_DEPTH=4 unless stated):
- Basic division: dividend 100, divisor 7, valid, clk_en=1 -> exactly 4 cycles later data_valid_o=1, quotient 14, remainder 2.
- Boundary values:
  - dividend 0xFFFF, divisor 1 -> quotient 0xFFFF, remainder 0;
  - dividend 3, divisor 10 -> quotient 0, remainder 3.
- Divide by zero: dividend 5, divisor 0 -> quotient 0xFFFF, remainder 5; with the macro defined, divide_by_zero_o=1 on the same cycle.
- Streaming with bubbles and stall: back-to-back 1000/3, bubble, 65535/255, then clk_en=0 for 3 cycles mid-flight -> results (333,1) and (257,0) in order. Valid slots are separated by one invalid cycle. Outputs are frozen during the stall and the latency counted in enabled cycles is 4.
- Reset mid-flight: issue 2 operations, assert rst_i for 1 cycle -> all outputs 0 next cycle and no data_valid_o pulse afterwards. A new operation 50/5 then returns (10,0) after 4 cycles.
- Parameter sweep: PIPELINE_DEPTH in {1,2,16}, DATA_WIDTH=32 with PIPELINE_DEPTH=8, 10k random operand pairs -> quotient and remainder match a reference model of dividend/divisor and dividend%divisor, using the divide-by-zero convention above.

Source files
------------

// File: rtl/pipelined_long_divider_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_long_divider_pkg
// Shared helpers for the pipelined long divider.
// Contents:
//   is_pow2 - constant function used for elaboration-time parameter checks.
// -----------------------------------------------------------------------------
package pipelined_long_divider_pkg;

  // True when value is a positive power of two.
  function automatic bit is_pow2(input int value);
    return (value > 32'sd0) && ((value & (value - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/pipelined_long_divider_stage.sv
// -----------------------------------------------------------------------------
// pipelined_long_divider_stage
// Combinational slice of a restoring long divider that resolves
// BITS_PER_STAGE quotient bits, MSB first.
// Ports:
//   partial_rem  - partial remainder entering the slice
//   partial_word - dividend/quotient shift word: the top bits still hold
//                  unconsumed dividend bits, the low bits hold resolved
//                  quotient bits
//   divisor      - divisor for this operation
//   next_rem     - partial remainder leaving the slice
//   next_word    - shift word after BITS_PER_STAGE bits have been resolved
// -----------------------------------------------------------------------------
module pipelined_long_divider_stage
  import pipelined_long_divider_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int BITS_PER_STAGE = 4
) (
  input  logic [DATA_WIDTH-1:0] partial_rem,
  input  logic [DATA_WIDTH-1:0] partial_word,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] next_rem,
  output logic [DATA_WIDTH-1:0] next_word
);

  localparam int REM_WIDTH = DATA_WIDTH + 1;

  // Restoring division steps, unrolled over the bits owned by this slice.
  always_comb begin
    logic [REM_WIDTH-1:0]  trial_s;
    logic [REM_WIDTH-1:0]  diff_s;
    logic [DATA_WIDTH-1:0] rem_s;
    logic [DATA_WIDTH-1:0] word_s;
    rem_s   = partial_rem;
    word_s  = partial_word;
    trial_s = '0;
    diff_s  = '0;
    for (int i = 0; i < BITS_PER_STAGE; i++) begin
      // The next dividend bit is always the MSB of the shift word; the
      // resolved quotient bit enters at the LSB, so after DATA_WIDTH steps
      // the word holds the full quotient.
      trial_s = {rem_s, word_s[DATA_WIDTH-1]};
      diff_s  = trial_s - {1'b0, divisor};
      if (trial_s >= {1'b0, divisor}) begin
        // The difference is below the divisor, so it fits DATA_WIDTH bits.
        rem_s  = diff_s[DATA_WIDTH-1:0];
        word_s = {word_s[DATA_WIDTH-2:0], 1'b1};
      end else begin
        // trial < divisor keeps the top bit clear.
        rem_s  = trial_s[DATA_WIDTH-1:0];
        word_s = {word_s[DATA_WIDTH-2:0], 1'b0};
      end
    end
    next_rem  = rem_s;
    next_word = word_s;
  end

endmodule

// File: rtl/pipelined_long_divider.sv
// -----------------------------------------------------------------------------
// pipelined_long_divider
// Streaming unsigned restoring divider with PIPELINE_DEPTH registered stages.
// One operation per enabled cycle, no backpressure, latency PIPELINE_DEPTH
// enabled cycles. Divide by zero yields quotient all ones, remainder dividend.
// Ports:
//   clk_i            - clock
//   rst_i            - synchronous active-high reset (overrides clk_en_i)
//   clk_en_i         - pipeline advance enable; 0 freezes every stage
//   dividend_i       - unsigned dividend
//   divisor_i        - unsigned divisor
//   data_valid_i     - operands valid this cycle
//   quotient_o       - quotient from the final stage register
//   remainder_o      - remainder from the final stage register
//   data_valid_o     - quotient_o / remainder_o valid
//   divide_by_zero_o - (only with PIPELINED_LONG_DIVIDER_DBZ_FLAG_EN) divisor
//                      was zero for the operation on the outputs
// Build option:
//   PIPELINED_LONG_DIVIDER_DBZ_FLAG_EN - adds divide_by_zero_o.
// -----------------------------------------------------------------------------
module pipelined_long_divider
  import pipelined_long_divider_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int PIPELINE_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clk_en_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  data_valid_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  data_valid_o
`ifdef PIPELINED_LONG_DIVIDER_DBZ_FLAG_EN
  ,
  output logic                  divide_by_zero_o
`endif
);

  localparam int BITS_PER_STAGE = DATA_WIDTH / PIPELINE_DEPTH;

  if ((DATA_WIDTH % PIPELINE_DEPTH) != 0) begin : g_bad_depth_divide
    $error("PIPELINE_DEPTH must divide DATA_WIDTH");
  end
  if ((PIPELINE_DEPTH < 1) || (PIPELINE_DEPTH > DATA_WIDTH)) begin : g_bad_depth_range
    $error("PIPELINE_DEPTH must lie in 1..DATA_WIDTH");
  end
  if (!is_pow2(DATA_WIDTH)) begin : g_bad_width
    $error("DATA_WIDTH must be a power of two");
  end

  // Stage registers.
  logic [DATA_WIDTH-1:0]     rem_r     [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0]     word_r    [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0]     divisor_r [PIPELINE_DEPTH];
  logic [PIPELINE_DEPTH-1:0] valid_r;

  // Stage inputs and combinational results.
  logic [DATA_WIDTH-1:0] stage_rem_s     [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] stage_word_s    [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] stage_divisor_s [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] next_rem_s      [PIPELINE_DEPTH];
  logic [DATA_WIDTH-1:0] next_word_s     [PIPELINE_DEPTH];

  for (genvar k = 0; k < PIPELINE_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Stage 0 starts from a zero remainder with the whole dividend unconsumed.
      assign stage_rem_s[k]     = '0;
      assign stage_word_s[k]    = dividend_i;
      assign stage_divisor_s[k] = divisor_i;
    end else begin : g_next
      assign stage_rem_s[k]     = rem_r[k-1];
      assign stage_word_s[k]    = word_r[k-1];
      assign stage_divisor_s[k] = divisor_r[k-1];
    end

    pipelined_long_divider_stage #(
      .DATA_WIDTH     (DATA_WIDTH),
      .BITS_PER_STAGE (BITS_PER_STAGE)
    ) u_stage (
      .partial_rem  (stage_rem_s[k]),
      .partial_word (stage_word_s[k]),
      .divisor      (stage_divisor_s[k]),
      .next_rem     (next_rem_s[k]),
      .next_word    (next_word_s[k])
    );
  end

  // Pipeline advance: reset clears everything, clk_en_i = 0 holds everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < PIPELINE_DEPTH; k++) begin
        rem_r[k]     <= '0;
        word_r[k]    <= '0;
        divisor_r[k] <= '0;
      end
      valid_r <= '0;
    end else if (clk_en_i) begin
      for (int k = 0; k < PIPELINE_DEPTH; k++) begin
        rem_r[k]     <= next_rem_s[k];
        word_r[k]    <= next_word_s[k];
        divisor_r[k] <= stage_divisor_s[k];
      end
      valid_r[0] <= data_valid_i;
      for (int k = 1; k < PIPELINE_DEPTH; k++) begin
        valid_r[k] <= valid_r[k-1];
      end
    end
  end

  assign quotient_o   = word_r[PIPELINE_DEPTH-1];
  assign remainder_o  = rem_r[PIPELINE_DEPTH-1];
  assign data_valid_o = valid_r[PIPELINE_DEPTH-1];

`ifdef PIPELINED_LONG_DIVIDER_DBZ_FLAG_EN
  logic [PIPELINE_DEPTH-1:0] dbz_r;

  // Zero-divisor flag, qualified by valid at entry so it never fires on bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbz_r <= '0;
    end else if (clk_en_i) begin
      dbz_r[0] <= data_valid_i && (divisor_i == '0);
      for (int k = 1; k < PIPELINE_DEPTH; k++) begin
        dbz_r[k] <= dbz_r[k-1];
      end
    end
  end

  assign divide_by_zero_o = dbz_r[PIPELINE_DEPTH-1];
`endif

endmodule

// File: tb/tb_pipelined_long_divider.sv
// -----------------------------------------------------------------------------
// tb_pipelined_long_divider
// Self-checking bench: directed cases followed by randomized traffic, compared
// every cycle against an arithmetic reference model (/ and %) held in a queue
// that mirrors the pipeline occupancy.
// -----------------------------------------------------------------------------
module tb_pipelined_long_divider;

  localparam int DW = 16;
  localparam int PD = 4;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          z;
  } entry_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          clk_en_i;
  logic [DW-1:0] dividend_i;
  logic [DW-1:0] divisor_i;
  logic          data_valid_i;
  logic [DW-1:0] quotient_o;
  logic [DW-1:0] remainder_o;
  logic          data_valid_o;
`ifdef PIPELINED_LONG_DIVIDER_DBZ_FLAG_EN
  logic          divide_by_zero_o;
`endif

  always #5 clk_i = ~clk_i;

  pipelined_long_divider #(
    .DATA_WIDTH     (DW),
    .PIPELINE_DEPTH (PD)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clk_en_i     (clk_en_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .data_valid_i (data_valid_i),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .data_valid_o (data_valid_o)
`ifdef PIPELINED_LONG_DIVIDER_DBZ_FLAG_EN
    ,
    .divide_by_zero_o (divide_by_zero_o)
`endif
  );

  int checks   = 0;
  int failures = 0;

  entry_t pipe[$];
  entry_t exp_out;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from integer arithmetic.
  function automatic entry_t ref_div(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b);
    entry_t e;
    e.v = v;
    e.z = v && (b == 16'd0);
    if (b == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic model_reset();
    entry_t zero_e;
    zero_e = '0;
    pipe.delete();
    for (int i = 0; i < PD; i++) pipe.push_back(zero_e);
  endtask

  // One clock: drive inputs, advance the model, check outputs 1 time unit after the edge.
  task automatic step(input logic rst, input logic en, input logic v,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input string tag);
    rst_i        = rst;
    clk_en_i     = en;
    data_valid_i = v;
    dividend_i   = a;
    divisor_i    = b;
    @(posedge clk_i);
    #1;
    if (rst) begin
      model_reset();
    end else if (en) begin
      pipe.push_back(ref_div(v, a, b));
      void'(pipe.pop_front());
    end
    exp_out = pipe[0];
    check_eq({tag, "/valid"}, {31'd0, data_valid_o}, {31'd0, exp_out.v});
    if (exp_out.v || rst) begin
      check_eq({tag, "/quotient"},  {16'd0, quotient_o},  {16'd0, exp_out.q});
      check_eq({tag, "/remainder"}, {16'd0, remainder_o}, {16'd0, exp_out.r});
`ifdef PIPELINED_LONG_DIVIDER_DBZ_FLAG_EN
      check_eq({tag, "/dbz"}, {31'd0, divide_by_zero_o}, {31'd0, exp_out.z});
`endif
    end
  endtask

  task automatic bubbles(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF, tag);
  endtask

  initial begin
    logic          en_v;
    logic          vld_v;
    logic          rst_v;
    logic [DW-1:0] a_v;
    logic [DW-1:0] b_v;

    rst_i        = 1'b1;
    clk_en_i     = 1'b0;
    data_valid_i = 1'b0;
    dividend_i   = '0;
    divisor_i    = '0;
    model_reset();

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, "reset");
    step(1'b1, 1'b1, 1'b1, 16'd9, 16'd3, "reset_over_en");

    // Basic division: result appears on the PD-th enabled edge.
    step(1'b0, 1'b1, 1'b1, 16'd100, 16'd7, "basic");
    bubbles(PD, "basic_lat");

    // Boundary values and divide by zero, back to back.
    step(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'd1,  "max_by_one");
    step(1'b0, 1'b1, 1'b1, 16'd3,    16'd10, "small_by_big");
    step(1'b0, 1'b1, 1'b1, 16'd5,    16'd0,  "div_zero");
    step(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, "max_by_max");
    step(1'b0, 1'b1, 1'b1, 16'd0,    16'd0,  "zero_by_zero");
    bubbles(PD, "boundary_drain");

    // Streaming with a bubble and a 3-cycle stall mid-flight.
    step(1'b0, 1'b1, 1'b1, 16'd1000,  16'd3,   "stream_a");
    step(1'b0, 1'b1, 1'b0, 16'h1234,  16'h0,   "stream_bubble");
    step(1'b0, 1'b1, 1'b1, 16'd65535, 16'd255, "stream_b");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'd77, 16'd0, "stream_stall");
    bubbles(PD, "stream_drain");

    // Reset mid-flight discards operations.
    step(1'b0, 1'b1, 1'b1, 16'd400, 16'd20, "flight_a");
    step(1'b0, 1'b1, 1'b1, 16'd401, 16'd21, "flight_b");
    step(1'b1, 1'b1, 1'b0, 16'd0,   16'd0,  "flight_reset");
    bubbles(PD + 2, "flight_quiet");
    step(1'b0, 1'b1, 1'b1, 16'd50, 16'd5, "after_reset");
    bubbles(PD, "after_reset_lat");

    // Randomized traffic with stalls, bubbles and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst_v = ($urandom_range(0, 199) == 0);
      en_v  = ($urandom_range(0, 9) < 8);
      vld_v = ($urandom_range(0, 9) < 7);
      a_v   = DW'($urandom);
      case ($urandom_range(0, 3))
        0:       b_v = DW'($urandom_range(0, 15));
        1:       b_v = DW'($urandom_range(0, 255));
        2:       b_v = a_v >> $urandom_range(0, 15);
        default: b_v = DW'($urandom);
      endcase
      step(rst_v, en_v, vld_v, a_v, b_v, "random");
    end
    bubbles(PD, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
